// File: rtl/delta_arbiter.sv
// delta_arbiter: round-robin merge of per-channel signed deltas into one registered stream.
// Build option DELTA_ACCUM_EN: colliding deltas are summed with saturation instead of overwritten.
module delta_arbiter #(
  parameter int                   W_CHAN       = 5,
  parameter int                   N_CHAN       = 8,
  parameter int                   W_DELTA      = 18,
  parameter int                   W_WR_ADDR    = 16,
  parameter int                   W_WR_CHAN    = 5,
  parameter int                   W_WR_DATA    = 48,
  parameter logic [W_WR_ADDR-1:0] EN_ADDR      = 16'h0040,
  parameter logic [W_WR_ADDR-1:0] OVF_CLR_ADDR = 16'h0041,
  parameter int                   IDLE_PERIOD  = 16
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic [N_CHAN-1:0]           req_dv_in,
  input  logic [N_CHAN*W_DELTA-1:0]   req_delta_in,
  input  logic                        wr_en,
  input  logic [W_WR_ADDR-1:0]        wr_addr,
  input  logic [W_WR_CHAN-1:0]        wr_chan,
  input  logic [W_WR_DATA-1:0]        wr_data,
  output logic                        dv_out,
  output logic [W_CHAN-1:0]           chan_out,
  output logic signed [W_DELTA-1:0]   delta_out,
  output logic [N_CHAN-1:0]           ovf_out
);

  logic [N_CHAN-1:0]         r_pendV;
  logic signed [W_DELTA-1:0] r_pendVal [N_CHAN];
  logic [N_CHAN-1:0]         r_en;
  logic [N_CHAN-1:0]         r_ovf;
  logic [W_CHAN-1:0]         r_rrPtr;
  logic [31:0]               r_runCnt;
  logic                      r_dv;
  logic [W_CHAN-1:0]         r_chan;
  logic signed [W_DELTA-1:0] r_delta;

  logic [N_CHAN-1:0]         w_enWr;
  logic [N_CHAN-1:0]         w_ovfClr;
  logic [N_CHAN-1:0]         w_arrive;
  logic [N_CHAN-1:0]         w_collide;
  logic [N_CHAN-1:0]         w_hiReq;
  logic [N_CHAN-1:0]         w_searchVec;
  logic [N_CHAN-1:0]         w_grantOh;
  logic signed [W_DELTA-1:0] w_newDelta [N_CHAN];
  logic                      w_forceIdle;
  logic                      w_grantV;
  logic [W_CHAN-1:0]         w_grantIdx;
  logic signed [W_DELTA-1:0] w_grantDelta;
  logic                      w_unusedWrData;

`ifdef DELTA_ACCUM_EN
  function automatic logic signed [W_DELTA-1:0] satAdd(input logic signed [W_DELTA-1:0] a,
                                                       input logic signed [W_DELTA-1:0] b);
    logic [W_DELTA:0] sum;
    sum = {a[W_DELTA-1], a} + {b[W_DELTA-1], b};
    if (sum[W_DELTA] != sum[W_DELTA-1])
      satAdd = sum[W_DELTA] ? {1'b1, {(W_DELTA-1){1'b0}}} : {1'b0, {(W_DELTA-1){1'b1}}};
    else
      satAdd = sum[W_DELTA-1:0];
  endfunction
`endif

  // Only bit 0 of the write data carries meaning (the enable value).
  assign w_unusedWrData = ^wr_data[W_WR_DATA-1:1];

  always_comb begin
    w_enWr   = '0;
    w_ovfClr = '0;
    for (int k = 0; k < N_CHAN; k++) begin
      if (wr_en && (wr_chan == W_WR_CHAN'(k))) begin
        w_enWr[k]   = (wr_addr == EN_ADDR);
        w_ovfClr[k] = (wr_addr == OVF_CLR_ADDR);
      end
    end
  end

  always_comb begin
    for (int k = 0; k < N_CHAN; k++) begin
      w_newDelta[k] = req_delta_in[k*W_DELTA +: W_DELTA];
    end
  end

  assign w_forceIdle = (IDLE_PERIOD != 0) && (r_runCnt == 32'(IDLE_PERIOD));
  assign w_grantV    = (|r_pendV) && !w_forceIdle;

  // Prefer pending channels at or above the pointer; fall back to the lowest one (wrap).
  always_comb begin
    w_hiReq = '0;
    for (int k = 0; k < N_CHAN; k++) begin
      w_hiReq[k] = r_pendV[k] && (W_CHAN'(k) >= r_rrPtr);
    end
    w_searchVec = (|w_hiReq) ? w_hiReq : r_pendV;
    w_grantIdx  = '0;
    for (int k = N_CHAN - 1; k >= 0; k--) begin
      if (w_searchVec[k]) w_grantIdx = W_CHAN'(k);
    end
    w_grantOh    = '0;
    w_grantDelta = '0;
    for (int k = 0; k < N_CHAN; k++) begin
      if (w_grantIdx == W_CHAN'(k)) begin
        w_grantOh[k] = w_grantV;
        w_grantDelta = r_pendVal[k];
      end
    end
  end

  assign w_arrive  = req_dv_in & r_en;
  assign w_collide = w_arrive & r_pendV & ~w_grantOh;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_pendV  <= '0;
      r_en     <= '1;
      r_ovf    <= '0;
      r_rrPtr  <= '0;
      r_runCnt <= '0;
      r_dv     <= 1'b0;
      r_chan   <= '0;
      r_delta  <= '0;
      for (int k = 0; k < N_CHAN; k++) r_pendVal[k] <= '0;
    end else begin
      r_dv <= w_grantV;
      if (w_grantV) begin
        r_chan   <= w_grantIdx;
        r_delta  <= w_grantDelta;
        r_rrPtr  <= (w_grantIdx == W_CHAN'(N_CHAN - 1)) ? '0 : w_grantIdx + 1'b1;
        r_runCnt <= (IDLE_PERIOD != 0) ? r_runCnt + 32'd1 : 32'd0;
      end else begin
        r_runCnt <= '0;
      end

      // A fresh arrival on a channel being granted this edge simply refills the slot.
      for (int k = 0; k < N_CHAN; k++) begin
        if (w_enWr[k]) r_en[k] <= wr_data[0];
        if (w_enWr[k] && !wr_data[0]) begin
          r_pendV[k] <= 1'b0;
        end else if (w_arrive[k]) begin
          r_pendV[k] <= 1'b1;
`ifdef DELTA_ACCUM_EN
          r_pendVal[k] <= w_collide[k] ? satAdd(r_pendVal[k], w_newDelta[k]) : w_newDelta[k];
`else
          r_pendVal[k] <= w_newDelta[k];
`endif
        end else if (w_grantOh[k]) begin
          r_pendV[k] <= 1'b0;
        end
        if (w_collide[k])     r_ovf[k] <= 1'b1;
        else if (w_ovfClr[k]) r_ovf[k] <= 1'b0;
      end
    end
  end

  assign dv_out    = r_dv;
  assign chan_out  = r_chan;
  assign delta_out = r_delta;
  assign ovf_out   = r_ovf;

endmodule

// File: tb/tb_delta_arbiter.sv
// Scoreboard bench for delta_arbiter: directed vectors push expected grants, monitors pop and compare.
// Instance A uses default parameters; instance B uses IDLE_PERIOD=4 for the forced-idle pattern.
module tb_delta_arbiter;
  localparam int NC = 8;
  localparam int WD = 18;
`ifdef DELTA_ACCUM_EN
  localparam bit ACCUM = 1'b1;
`else
  localparam bit ACCUM = 1'b0;
`endif
  localparam logic [15:0] EN_ADDR      = 16'h0040;
  localparam logic [15:0] OVF_CLR_ADDR = 16'h0041;

  typedef struct packed {
    logic [4:0]  chan;
    logic [17:0] delta;
  } grantT;

  typedef struct packed {
    logic        dv;
    logic [4:0]  chan;
    logic [17:0] delta;
  } slotT;

  logic clk = 1'b0;
  logic rst;

  logic [NC-1:0]    reqDvA;
  logic [NC*WD-1:0] reqDeltaA;
  logic             wrEnA;
  logic [15:0]      wrAddrA;
  logic [4:0]       wrChanA;
  logic [47:0]      wrDataA;
  logic             dvA;
  logic [4:0]       chanA;
  logic [17:0]      deltaA;
  logic [NC-1:0]    ovfA;

  logic [NC-1:0]    reqDvB;
  logic [NC*WD-1:0] reqDeltaB;
  logic             dvB;
  logic [4:0]       chanB;
  logic [17:0]      deltaB;
  logic [NC-1:0]    ovfB;

  grantT expA[$];
  slotT  expB[$];
  grantT monA;
  slotT  monB;
  int    errors = 0;
  int    checks = 0;
  int    grantCntA = 0;
  bit    armB = 1'b0;
  logic [17:0] stimDelta [NC];

  delta_arbiter dutA (
    .clk_in(clk), .rst_in(rst),
    .req_dv_in(reqDvA), .req_delta_in(reqDeltaA),
    .wr_en(wrEnA), .wr_addr(wrAddrA), .wr_chan(wrChanA), .wr_data(wrDataA),
    .dv_out(dvA), .chan_out(chanA), .delta_out(deltaA), .ovf_out(ovfA)
  );

  delta_arbiter #(.IDLE_PERIOD(4)) dutB (
    .clk_in(clk), .rst_in(rst),
    .req_dv_in(reqDvB), .req_delta_in(reqDeltaB),
    .wr_en(1'b0), .wr_addr(16'h0000), .wr_chan(5'd0), .wr_data(48'd0),
    .dv_out(dvB), .chan_out(chanB), .delta_out(deltaB), .ovf_out(ovfB)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic packDeltas();
    for (int k = 0; k < NC; k++) reqDeltaA[k*WD +: WD] = stimDelta[k];
  endtask

  task automatic applyStimulus(input logic [NC-1:0] mask);
    packDeltas();
    reqDvA = mask;
    tick();
    reqDvA = '0;
  endtask

  task automatic writeCfg(input logic [15:0] addr, input logic [4:0] chan, input logic [47:0] data);
    wrEnA   = 1'b1;
    wrAddrA = addr;
    wrChanA = chan;
    wrDataA = data;
    tick();
    wrEnA = 1'b0;
  endtask

  task automatic pushA(input logic [4:0] chan, input logic [17:0] delta);
    grantT g;
    g.chan  = chan;
    g.delta = delta;
    expA.push_back(g);
  endtask

  task automatic drainA(input string name);
    int n = 0;
    while (expA.size() != 0 && n < 40) begin
      tick();
      n++;
    end
    repeat (2) tick();
    checkOutput(name, expA.size(), 0);
  endtask

  // Monitor A: every presented grant must match the oldest expected grant.
  always @(negedge clk) begin
    if (dvA === 1'b1) begin
      grantCntA++;
      if (expA.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpectedGrantA: got chan %0d delta %0d, expected no grant", chanA, deltaA);
      end else begin
        monA = expA.pop_front();
        checkOutput("grantA.chan", chanA, monA.chan);
        checkOutput("grantA.delta", deltaA, monA.delta);
      end
    end
  end

  // Monitor B: cycle-by-cycle expectation including forced idle slots.
  always @(negedge clk) begin
    if (armB && expB.size() != 0) begin
      monB = expB.pop_front();
      checkOutput("slotB.dv", dvB, monB.dv);
      if (monB.dv) begin
        checkOutput("slotB.chan", chanB, monB.chan);
        checkOutput("slotB.delta", deltaB, monB.delta);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cntStart;
    int gi;
    slotT s;
    rst       = 1'b1;
    reqDvA    = '0;
    reqDeltaA = '0;
    wrEnA     = 1'b0;
    wrAddrA   = '0;
    wrChanA   = '0;
    wrDataA   = '0;
    reqDvB    = '0;
    reqDeltaB = '0;
    for (int k = 0; k < NC; k++) stimDelta[k] = '0;
    repeat (3) tick();
    rst = 1'b0;
    checkOutput("reset.dv", dvA, 0);
    checkOutput("reset.chan", chanA, 0);
    checkOutput("reset.delta", deltaA, 0);
    checkOutput("reset.ovf", ovfA, 0);
    checkOutput("reset.dvB", dvB, 0);

    // All eight channels at once: eight back-to-back grants in channel order.
    for (int k = 0; k < NC; k++) begin
      stimDelta[k] = 18'd5;
      pushA(5'(k), 18'd5);
    end
    cntStart = grantCntA;
    applyStimulus(8'hFF);
    repeat (9) tick();
    checkOutput("burst.count", grantCntA - cntStart, 8);
    checkOutput("burst.dvAfter", dvA, 0);
    checkOutput("burst.queue", expA.size(), 0);

    // Collision on channel 2 while channels 0 and 1 are served first.
    for (int k = 0; k < NC; k++) stimDelta[k] = '0;
    stimDelta[0] = 18'd1;
    stimDelta[1] = 18'd1;
    stimDelta[2] = 18'd100;
    pushA(5'd0, 18'd1);
    pushA(5'd1, 18'd1);
    pushA(5'd2, ACCUM ? 18'd150 : 18'd50);
    applyStimulus(8'h07);
    stimDelta[2] = 18'd50;
    applyStimulus(8'h04);
    drainA("collide.drain");
    checkOutput("collide.ovf", ovfA, 8'h04);
    writeCfg(OVF_CLR_ADDR, 5'd2, 48'd1);
    checkOutput("ovfClear.ovf", ovfA, 8'h00);

    // Saturating collision: 131000 + 131000 against the 18-bit signed ceiling.
    stimDelta[3] = 18'd7;
    stimDelta[2] = 18'd131000;
    pushA(5'd3, 18'd7);
    pushA(5'd2, ACCUM ? 18'd131071 : 18'd131000);
    applyStimulus(8'h0C);
    applyStimulus(8'h04);
    drainA("saturate.drain");
    checkOutput("saturate.ovf", ovfA, 8'h04);

    // New request arriving on the very edge its channel is granted: no collision.
    stimDelta[5] = 18'd10;
    pushA(5'd5, 18'd10);
    pushA(5'd5, 18'd20);
    applyStimulus(8'h20);
    stimDelta[5] = 18'd20;
    applyStimulus(8'h20);
    drainA("sameEdge.drain");
    checkOutput("sameEdge.ovf", ovfA, 8'h04);

    // Disable channel 3 while it is pending; its requests are dropped until re-enabled.
    stimDelta[3] = 18'd33;
    stimDelta[6] = 18'd66;
    stimDelta[7] = 18'd77;
    pushA(5'd6, 18'd66);
    pushA(5'd7, 18'd77);
    applyStimulus(8'hC8);
    writeCfg(EN_ADDR, 5'd3, 48'd0);
    drainA("disable.drain");
    stimDelta[3] = 18'd35;
    applyStimulus(8'h08);
    repeat (4) tick();
    writeCfg(EN_ADDR, 5'd3, 48'd1);
    stimDelta[3] = 18'd34;
    pushA(5'd3, 18'd34);
    applyStimulus(8'h08);
    drainA("reenable.drain");

    // Writes to out-of-range channels or unknown addresses change nothing.
    writeCfg(EN_ADDR, 5'd8, 48'd0);
    writeCfg(16'h0042, 5'd1, 48'd0);
    writeCfg(OVF_CLR_ADDR, 5'd10, 48'd1);
    checkOutput("ignoredWr.ovf", ovfA, 8'h04);
    stimDelta[0] = 18'd1;
    stimDelta[1] = 18'd2;
    pushA(5'd0, 18'd1);
    pushA(5'd1, 18'd2);
    applyStimulus(8'h03);
    drainA("ignoredWr.drain");

    // One-cycle reset with four channels pending; traffic during reset is dropped.
    stimDelta[0] = 18'd11;
    stimDelta[1] = 18'd12;
    stimDelta[2] = 18'd13;
    stimDelta[3] = 18'd14;
    packDeltas();
    reqDvA = 8'h0F;
    tick();
    stimDelta[7] = 18'd70;
    packDeltas();
    reqDvA  = 8'h80;
    wrEnA   = 1'b1;
    wrAddrA = EN_ADDR;
    wrChanA = 5'd7;
    wrDataA = 48'd0;
    rst     = 1'b1;
    tick();
    rst    = 1'b0;
    reqDvA = '0;
    wrEnA  = 1'b0;
    checkOutput("pulse.dv", dvA, 0);
    checkOutput("pulse.chan", chanA, 0);
    checkOutput("pulse.delta", deltaA, 0);
    checkOutput("pulse.ovf", ovfA, 8'h00);
    stimDelta[0] = 18'd10;
    stimDelta[6] = 18'd66;
    stimDelta[7] = 18'd77;
    pushA(5'd0, 18'd10);
    pushA(5'd6, 18'd66);
    pushA(5'd7, 18'd77);
    applyStimulus(8'hC1);
    tick();
    checkOutput("postReset.dv", dvA, 1);
    drainA("postReset.drain");

    // Instance B: all requesters held valid, idle slot after every four grants.
    reqDeltaB = '0;
    gi = 0;
    for (int c = 0; c < 20; c++) begin
      if (c % 5 == 4) begin
        s.dv    = 1'b0;
        s.chan  = '0;
        s.delta = '0;
      end else begin
        s.dv    = 1'b1;
        s.chan  = 5'(gi % 8);
        s.delta = '0;
        gi++;
      end
      expB.push_back(s);
    end
    reqDvB = 8'hFF;
    tick();
    tick();
    armB = 1'b1;
    repeat (21) tick();
    reqDvB = '0;
    checkOutput("idleB.queue", expB.size(), 0);
    checkOutput("idleB.ovf", ovfB, 8'hFF);

    checkOutput("finalA.queue", expA.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
